// File: rtl/fanin_req_rr_arb_n.sv
// Round-robin fan-in of N_CH request channels onto one registered downstream request slot.
// Grants are combinational; the winner's payload is captured into the slot on the same edge.
module fanin_req_rr_arb_n #(
  parameter int N_CH       = 4,
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int BE_WIDTH   = DATA_WIDTH / 8,
  parameter int ID_WIDTH   = 16,
  localparam int CH_W      = (N_CH > 2) ? $clog2(N_CH) : 1
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [N_CH-1:0]              data_req_i,
  input  logic [N_CH*ADDR_WIDTH-1:0]   data_add_i,
  input  logic [N_CH-1:0]              data_wen_i,
  input  logic [N_CH*DATA_WIDTH-1:0]   data_wdata_i,
  input  logic [N_CH*BE_WIDTH-1:0]     data_be_i,
  input  logic [N_CH*ID_WIDTH-1:0]     data_ID_i,
  output logic [N_CH-1:0]              data_gnt_o,
  output logic                         data_req_o,
  output logic [ADDR_WIDTH-1:0]        data_add_o,
  output logic                         data_wen_o,
  output logic [DATA_WIDTH-1:0]        data_wdata_o,
  output logic [BE_WIDTH-1:0]          data_be_o,
  output logic [ID_WIDTH-1:0]          data_ID_o,
  output logic [CH_W-1:0]              data_chan_o,
  input  logic                         data_gnt_i
);

  logic                  valid_r;
  logic [CH_W-1:0]       rr_ptr_r;
  logic                  slot_free_s;
  logic                  any_req_s;
  logic [2*N_CH-1:0]     req_dbl_s;
  logic [N_CH-1:0]       req_rot_s;
  logic [CH_W-1:0]       first_s;
  logic [CH_W:0]         win_sum_s;
  logic [CH_W-1:0]       win_s;
  logic [CH_W-1:0]       rr_next_s;
  logic [N_CH-1:0]       gnt_s;
  logic [ADDR_WIDTH-1:0] add_mux_s;
  logic                  wen_mux_s;
  logic [DATA_WIDTH-1:0] wdata_mux_s;
  logic [BE_WIDTH-1:0]   be_mux_s;
  logic [ID_WIDTH-1:0]   id_mux_s;

  assign slot_free_s = ~valid_r | data_gnt_i;
  assign any_req_s   = |data_req_i;
  assign req_dbl_s   = {data_req_i, data_req_i};
  assign req_rot_s   = N_CH'(req_dbl_s >> rr_ptr_r);
  assign win_sum_s   = {1'b0, rr_ptr_r} + {1'b0, first_s};
  assign win_s       = (win_sum_s >= (CH_W+1)'(N_CH)) ? CH_W'(win_sum_s - (CH_W+1)'(N_CH))
                                                      : CH_W'(win_sum_s);
  assign rr_next_s   = (win_s == CH_W'(N_CH - 1)) ? CH_W'(0) : win_s + CH_W'(1);

  // Lowest set bit of the rotated request vector is the offset of the winner from rr_ptr
  always_comb begin
    first_s = '0;
    for (int k = N_CH - 1; k >= 0; k--) begin
      first_s = req_rot_s[k] ? CH_W'(k) : first_s;
    end
  end

  // Payload selection of the winning channel
  always_comb begin
    add_mux_s   = '0;
    wen_mux_s   = 1'b0;
    wdata_mux_s = '0;
    be_mux_s    = '0;
    id_mux_s    = '0;
    for (int i = 0; i < N_CH; i++) begin
      add_mux_s   = (win_s == CH_W'(i)) ? data_add_i[i*ADDR_WIDTH +: ADDR_WIDTH]   : add_mux_s;
      wen_mux_s   = (win_s == CH_W'(i)) ? data_wen_i[i]                            : wen_mux_s;
      wdata_mux_s = (win_s == CH_W'(i)) ? data_wdata_i[i*DATA_WIDTH +: DATA_WIDTH] : wdata_mux_s;
      be_mux_s    = (win_s == CH_W'(i)) ? data_be_i[i*BE_WIDTH +: BE_WIDTH]        : be_mux_s;
      id_mux_s    = (win_s == CH_W'(i)) ? data_ID_i[i*ID_WIDTH +: ID_WIDTH]        : id_mux_s;
    end
  end

  // Grant is held off during reset so upstream never sees a handshake that is not captured
  always_comb begin
    gnt_s = '0;
    if (rst_n && slot_free_s && any_req_s) begin
      gnt_s[win_s] = 1'b1;
    end else begin
      gnt_s = '0;
    end
  end

  assign data_gnt_o = gnt_s;
  assign data_req_o = valid_r;

  // Output slot, round-robin pointer and captured payload
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_r      <= 1'b0;
      rr_ptr_r     <= '0;
      data_chan_o  <= '0;
      data_add_o   <= '0;
      data_wen_o   <= 1'b0;
      data_wdata_o <= '0;
      data_be_o    <= '0;
      data_ID_o    <= '0;
    end else if (slot_free_s) begin
      if (any_req_s) begin
        valid_r      <= 1'b1;
        rr_ptr_r     <= rr_next_s;
        data_chan_o  <= win_s;
        data_add_o   <= add_mux_s;
        data_wen_o   <= wen_mux_s;
        data_wdata_o <= wdata_mux_s;
        data_be_o    <= be_mux_s;
        data_ID_o    <= id_mux_s;
      end else begin
        valid_r <= 1'b0;
      end
    end
  end

endmodule

// File: doc/fanin_req_rr_arb_n.md
FANIN_REQ_RR_ARB_N -- requirements
Module: fanin_req_rr_arb_n

Interface
REQ-001 Parameter N_CH, default 4: number of request channels; legal range 2..32, any value including non-power-of-two.
REQ-002 Parameter ADDR_WIDTH, default 32: address width.
REQ-003 Parameter DATA_WIDTH, default 32: write-data width.
REQ-004 Parameter BE_WIDTH, default DATA_WIDTH/8: byte-enable width.
REQ-005 Parameter ID_WIDTH, default 16: transaction ID width.
REQ-006 Derived CH_W = max(1, clog2(N_CH)): channel-index width.
REQ-007 clk  input  1  single clock, all state on rising edge.
REQ-008 rst_n  input  1  asynchronous active-low reset.
REQ-009 data_req_i  input  N_CH  per-channel request.
REQ-010 data_add_i  input  N_CH*ADDR_WIDTH  per-channel address, channel i at slice [i*ADDR_WIDTH +: ADDR_WIDTH].
REQ-011 data_wen_i  input  N_CH  per-channel write-enable (1 = read).
REQ-012 data_wdata_i  input  N_CH*DATA_WIDTH  per-channel write data, same slicing.
REQ-013 data_be_i  input  N_CH*BE_WIDTH  per-channel byte enables, same slicing.
REQ-014 data_ID_i  input  N_CH*ID_WIDTH  per-channel ID, same slicing.
REQ-015 data_gnt_o  output  N_CH  per-channel grant, one-hot or zero.
REQ-016 data_req_o, data_add_o, data_wen_o, data_wdata_o, data_be_o, data_ID_o  output  1/ADDR_WIDTH/1/DATA_WIDTH/BE_WIDTH/ID_WIDTH  registered downstream request and payload.
REQ-017 data_chan_o  output  CH_W  index of the channel owning the current downstream request, for response routing.
REQ-018 data_gnt_i  input  1  downstream grant; transfer occurs when data_req_o & data_gnt_i.

Function
REQ-019 Output stage is one registered slot; valid flag drives data_req_o directly; no combinational path from data_req_i to data_req_o.
REQ-020 slot_free = ~valid | data_gnt_i; arbitration is enabled only when slot_free.
REQ-021 When slot_free and any data_req_i set, the winner w is the first requesting channel scanning rr_ptr, rr_ptr+1, ..., wrapping N_CH-1 -> 0.
REQ-022 data_gnt_o[w] = 1 combinationally in that cycle; all other grants 0; grants 0 when slot not free or no request.
REQ-023 On an edge with a grant: payload of w and chan = w are loaded, valid <= 1, rr_ptr <= (w == N_CH-1) ? 0 : w+1.
REQ-024 On an edge with slot_free and no request: valid <= 0, payload registers hold, rr_ptr holds.
REQ-025 While valid & ~data_gnt_i: payload, chan, valid and rr_ptr hold unchanged; data_gnt_o all 0 (backpressure).
REQ-026 Latency: input grant at cycle t -> data_req_o with that payload at cycle t+1.
REQ-027 Throughput: with data_gnt_i held 1, one transfer per cycle sustained.
REQ-028 Fairness: a continuously requesting channel is granted within N_CH grant events.
REQ-029 data_gnt_i while valid = 0 is ignored.
REQ-030 Requester contract: a channel holds req and payload stable until granted; block does not check this.

Reset
REQ-031 rst_n low, asynchronously: valid = 0 (data_req_o = 0), rr_ptr = 0, data_chan_o = 0, all payload outputs = 0; data_gnt_o = 0 while rst_n low.
REQ-032 Reset mid-transfer discards the buffered request without issuing it; first arbitration after release starts at channel 0.

Verification (N_CH=4, data_gnt_i=1 unless stated)
REQ-033 All four req high from reset release -> gnt_o sequence 0001,0010,0100,1000,0001; data_chan_o one cycle later 0,1,2,3,0.
REQ-034 Only channel 2 requests, add=0x100 -> gnt_o=0100 each cycle; next cycle data_req_o=1, data_add_o=0x100, data_chan_o=2; rr_ptr=3.
REQ-035 Grant ch1, then data_gnt_i=0 for 3 cycles with all req high -> data_req_o stays 1 with ch1 payload, gnt_o=0000; on gnt_i=1, ch2 granted same cycle.
REQ-036 rr_ptr=3, only ch0 and ch3 request -> ch3 granted first, then ch0 (wrap), rr_ptr=1.
REQ-037 rst_n asserted while valid=1, gnt_i=0 -> data_req_o=0 immediately; after release, ch0 wins with all requesting.
REQ-038 N_CH=3 build, all requesting -> grant order 0,1,2,0; data_chan_o never 3.
